// File: rtl/rx_arb_pkg.sv
// Shared types and constants for the two-source receive-byte arbiter.
package rx_arb_pkg;

    localparam int unsigned DEPTH_DEFAULT = 16;
    localparam int unsigned CNT_W         = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        SRC_UART = 1'b0,
        SRC_AUX  = 1'b1
    } src_idx_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO: register array, wrapping pointers, registered level
// and empty flag. Full/empty come from the level count only.
module rx_byte_fifo
    import rx_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  byte_t       push_data,
    input  logic        pop,
    output byte_t       head,
    output logic [AW:0] level,
    output logic        empty
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Qualify requests: no write when full, no read when empty.
    always_comb begin
        do_push = push && (level != FULL_LEVEL);
        do_pop  = pop && !empty;
    end

    // Byte storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and empty flag move together on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: begin
                    level <= level + 1'b1;
                    empty <= 1'b0;
                end
                2'b01: begin
                    level <= level - 1'b1;
                    empty <= (level == ONE_LEVEL);
                end
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rx_byte_arbiter.sv
// Round-robin merge of UART-bridge and aux-link byte streams into one
// show-ahead FIFO read through the rx_char / rx_fifo_empty / rx_fifo_read
// PIO triplet. Optional per-source statistics when RX_ARB_STATS_EN is defined.
module rx_byte_arbiter
    import rx_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [7:0]       src0_data,
    input  logic             src0_valid,
    output logic             src0_ready,
    input  logic [7:0]       src1_data,
    input  logic             src1_valid,
    output logic             src1_ready,
    output logic [7:0]       rx_char,
    output logic             rx_fifo_empty,
    input  logic             rx_fifo_read,
`ifdef RX_ARB_STATS_EN
    output logic [CNT_W-1:0] src0_count,
    output logic [CNT_W-1:0] src1_count,
    output logic             underflow,
    input  logic             stats_clr,
`endif
    output logic [AW:0]      fifo_level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    src_idx_t last_grant;
    logic     rd_req_q;
    logic     pop_evt;
    logic     grant0;
    logic     grant1;
    logic     push;
    byte_t    push_data;

    // Grant from registered state only; a same-cycle pop never opens a slot.
    // Readies are forced low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (fifo_level != FULL_LEVEL) begin
            if (src0_valid && src1_valid) begin
                grant0 = (last_grant == SRC_AUX);
                grant1 = (last_grant == SRC_UART);
            end else begin
                grant0 = src0_valid;
                grant1 = src1_valid;
            end
        end
        src0_ready = grant0 && !reset_reset;
        src1_ready = grant1 && !reset_reset;
        push       = grant0 || grant1;
        push_data  = grant1 ? src1_data : src0_data;
        pop_evt    = rx_fifo_read && !rd_req_q;
    end

    // Remember the last winner so a contest alternates.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            last_grant <= SRC_AUX;
        end else if (push) begin
            last_grant <= grant1 ? SRC_AUX : SRC_UART;
        end
    end

    // Rising-edge detector on the PIO pop level.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) rd_req_q <= 1'b0;
        else             rd_req_q <= rx_fifo_read;
    end

    rx_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_evt),
        .head      (rx_char),
        .level     (fifo_level),
        .empty     (rx_fifo_empty)
    );

`ifdef RX_ARB_STATS_EN
    // Saturating accept counters and sticky underflow; clear has priority.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            src0_count <= '0;
            src1_count <= '0;
            underflow  <= 1'b0;
        end else if (stats_clr) begin
            src0_count <= '0;
            src1_count <= '0;
            underflow  <= 1'b0;
        end else begin
            if (grant0 && src0_count != '1) src0_count <= src0_count + 1'b1;
            if (grant1 && src1_count != '1) src1_count <= src1_count + 1'b1;
            if (pop_evt && rx_fifo_empty)   underflow  <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/rx_byte_arbiter.md
Name: rx_byte_arbiter

Overview:
Shares the processor's single-byte receive channel (rx_char / rx_fifo_empty / rx_fifo_read PIO triplet) between two byte sources: UART-bridge RX and an auxiliary command link. Round-robin arbitration into a shared show-ahead FIFO. Software sees one byte stream; it pops by pulsing rx_fifo_read. Sits in the top level between the byte sources and the Nios II system instance, all on the system clock.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
AW, log2(DEPTH), pointer width; derived, never overridden.

Ports:
clk_clk  in  1  system clock, same clock as the Nios II system.
reset_reset  in  1  asynchronous, active-high reset.
src0_data  in  8  source 0 byte (UART bridge).
src0_valid  in  1  source 0 byte available.
src0_ready  out  1  source 0 byte accepted this cycle when valid is also high.
src1_data  in  8  source 1 byte (aux link).
src1_valid  in  1  source 1 byte available.
src1_ready  out  1  source 1 byte accepted this cycle when valid is also high.
rx_char  out  8  FIFO head byte; to the PIO input.
rx_fifo_empty  out  1  high when the FIFO holds 0 bytes; to the PIO input.
rx_fifo_read  in  1  pop request level from the PIO output; acts on its rising edge.
fifo_level  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - rd_ptr = wr_ptr = 0, fifo_level = 0.
  - rx_fifo_empty = 1, rx_char = 0.
  - src0_ready = src1_ready = 0.
  - last_grant = 1, so source 0 wins the first contest.
  - rd_req_q = 0.
- Reset mid-operation discards all stored bytes. A handshake in flight on the reset edge is not counted.
- Grant logic (combinational, from registered state):
  - If fifo_level == DEPTH, no grant; both readies are 0.
  - Else if exactly one valid is high, grant that source.
  - Else if both are high, grant the source != last_grant.
  - srcN_ready = grantN. Readies never depend on a pop in the same cycle, so a full FIFO stalls even while a pop is occurring.
- Push: on a clock edge with srcN_valid & srcN_ready:
  - mem[wr_ptr] <= srcN_data; wr_ptr increments, wrapping modulo DEPTH.
  - last_grant <= N.
  - last_grant is unchanged on cycles with no push.
- Pop detect:
  - rd_req_q <= rx_fifo_read every cycle.
  - pop_evt = rx_fifo_read & ~rd_req_q.
  - A level held high gives exactly one pop.
- Pop: pop_evt & (fifo_level != 0) increments rd_ptr, wrapping. pop_evt while empty is ignored, with no state change.
- Occupancy on the clock edge:
  - Push and pop together: level unchanged.
  - Push only: +1. Pop only: -1.
  - rx_fifo_empty and fifo_level are registered and updated on the same edge as the pointer change.
- rx_char = mem[rd_ptr], a mux over the register array (show-ahead).
  - It is valid whenever rx_fifo_empty = 0, including the first cycle after empty deasserts.
  - It updates on the edge that advances rd_ptr.
- Latency:
  - Byte accepted at edge k is visible on rx_char, with rx_fifo_empty = 0, after edge k if the FIFO was empty.
  - The pop edge is the first clk_clk edge sampling rx_fifo_read high after a low sample.
- Ordering: per-source order is preserved. Interleave is strictly alternating while both sources stay valid and the FIFO is not full.
- Wrap-around: pointers are AW bits and wrap naturally. Full/empty is decided by fifo_level, never by pointer compare.

Optional Feature:
Macro RX_ARB_STATS_EN.
- Defined: adds ports src0_count out 16, src1_count out 16, underflow out 1, stats_clr in 1.
  - Each counter increments on its source's accepted byte and saturates at 0xFFFF.
  - underflow goes sticky high on pop_evt while empty.
  - stats_clr (synchronous, level) zeroes counters and underflow; clear wins over a same-cycle increment.
  - All reset to 0.
- Undefined: these ports and registers do not exist; core behaviour is identical.

Decomposition:
- Package rx_arb_pkg:
  - DEPTH_DEFAULT = 16.
  - byte_t (8-bit logic).
  - src_idx_t enum SRC_UART = 0, SRC_AUX = 1.
  - CNT_W = 16 for statistics.
- Sub-module rx_byte_fifo: register array, pointers, level and empty flag. Push/pop inputs, head/level/empty outputs.
- The top holds the grant logic, the rising-edge pop detector and the optional statistics.

Test Plan:
1. Reset, then src0 sends 0xA5 alone → after one edge rx_fifo_empty = 0, rx_char = 0xA5, fifo_level = 1. Pulse rx_fifo_read high for 3 cycles → exactly one pop, empty = 1, level = 0.
2. Both sources valid continuously: src0 sends 0x10..0x13, src1 sends 0x20..0x23 → FIFO order 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23.
3. src0 pushes 16 bytes, no pops → level = 16, src0_ready = 0 and src1_ready = 0 while valid stays high. One pop → level 15, then the next push is granted on the following edge. Level never exceeds 16.
4. Level = 5, push and rx_fifo_read rising edge on the same edge → level stays 5, rx_char advances to the next byte, the new byte is stored at the tail.
5. Empty FIFO, rx_fifo_read pulses → no pointer change, level = 0. With RX_ARB_STATS_EN, underflow = 1 until stats_clr.
6. Fill 10 bytes, assert reset_reset asynchronously mid-cycle → outputs go to reset values immediately: empty = 1, level = 0, readies = 0. After release, the next src1 byte is the first byte out.
